// File: rtl/cpu_types_pkg.sv
// Shared CPU types: data word, memory-stage FSM states, stall counter width.
package cpu_types_pkg;

  localparam int STALL_CNT_W = 16;

  typedef logic [31:0] word_t;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ACCESS = 3'd1,
    DONE   = 3'd2,
    FLUSH  = 3'd3,
    HALTED = 3'd4
  } memstate_t;

  // Word accesses only: the two low address bits must be zero.
  function automatic logic is_aligned(input word_t addr);
    return (addr[1:0] == 2'b00);
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter: counts cycles with i_inc high, sticks at all-ones.
module sat_counter
  import cpu_types_pkg::*;
#(
  parameter int W = STALL_CNT_W
) (
  input  logic         CLK,
  input  logic         nRST,
  input  logic         i_inc,
  output logic [W-1:0] o_cnt
);

  logic [W-1:0] r_cnt;

  // Count up while enabled; hold once every bit is set so it never wraps.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_cnt <= '0;
    end else if (i_inc && (r_cnt != {W{1'b1}})) begin
      r_cnt <= r_cnt + W'(1);
    end
  end

  assign o_cnt = r_cnt;

endmodule

// File: rtl/mem_access_ctrl.sv
// Memory-stage controller: turns EX/MEM load/store requests into dcache
// accesses, stalls the pipeline while they complete, and sequences the
// halt-time dcache flush.
//
// Handshake: a request is accepted in IDLE when an enable is set with a
// word-aligned address; it is then presented to the dcache from latched
// registers for as long as the FSM sits in ACCESS, and completes on the first
// cycle dhit is seen there. wb_valid_o is the one-cycle completion strobe.
module mem_access_ctrl
  import cpu_types_pkg::*;
(
  input  logic                   CLK,
  input  logic                   nRST,
  input  logic                   ex_DRen_i,
  input  logic                   ex_DWen_i,
  input  word_t                  ex_addr_i,
  input  word_t                  ex_store_i,
  input  logic                   ex_halt_i,
  output logic                   dmemREN,
  output logic                   dmemWEN,
  output word_t                  dmemaddr,
  output word_t                  dmemstore,
  input  logic                   dhit,
  input  word_t                  dmemload,
  output logic                   dcache_halt_o,
  input  logic                   flushed_i,
  output logic                   mem_stall_o,
  output logic                   wb_valid_o,
  output word_t                  wb_load_o,
  output logic                   halt_o,
  output logic                   align_err_o,
  output logic [STALL_CNT_W-1:0] stall_cnt_o,
  output memstate_t              dbg_state_o
);

  memstate_t r_state;
  memstate_t w_next;
  logic      r_is_wr;
  word_t     r_addr;
  word_t     r_data;
  word_t     r_wb_load;
  logic      w_any_en;
  logic      w_req;
  logic      w_misalign;

  assign w_any_en   = ex_DRen_i | ex_DWen_i;
  assign w_req      = w_any_en & is_aligned(ex_addr_i);
  assign w_misalign = w_any_en & ~is_aligned(ex_addr_i);

  // State register; reset drops any in-flight access immediately.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Latch the accepted request so the dcache sees stable values in ACCESS.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_is_wr <= 1'b0;
      r_addr  <= '0;
      r_data  <= '0;
    end else if ((r_state == IDLE) && w_req) begin
      r_is_wr <= ex_DWen_i;
      r_addr  <= ex_addr_i;
      r_data  <= ex_store_i;
    end
  end

  // Capture load data on read completion; writes leave it untouched.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_wb_load <= '0;
    end else if ((r_state == ACCESS) && dhit && !r_is_wr) begin
      r_wb_load <= dmemload;
    end
  end

  // Next-state and output decode; requests take priority over halt.
  always_comb begin
    w_next        = r_state;
    dmemREN       = 1'b0;
    dmemWEN       = 1'b0;
    dmemaddr      = '0;
    dmemstore     = '0;
    dcache_halt_o = 1'b0;
    mem_stall_o   = 1'b0;
    wb_valid_o    = 1'b0;
    halt_o        = 1'b0;
    align_err_o   = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (w_req) begin
          mem_stall_o = 1'b1;
          w_next      = ACCESS;
        end else if (w_misalign) begin
          align_err_o = 1'b1;
        end else if (ex_halt_i) begin
          w_next = FLUSH;
        end
      end
      ACCESS: begin
        mem_stall_o = 1'b1;
        dmemREN     = ~r_is_wr;
        dmemWEN     = r_is_wr;
        dmemaddr    = r_addr;
        dmemstore   = r_data;
        if (dhit) begin
          w_next = DONE;
        end
      end
      DONE: begin
        wb_valid_o = 1'b1;
        w_next     = IDLE;
      end
      FLUSH: begin
        mem_stall_o   = 1'b1;
        dcache_halt_o = 1'b1;
        if (flushed_i) begin
          w_next = HALTED;
        end
      end
      HALTED: begin
        mem_stall_o   = 1'b1;
        dcache_halt_o = 1'b1;
        halt_o        = 1'b1;
      end
      default: begin
        w_next = IDLE;
      end
    endcase
  end

  assign wb_load_o   = r_wb_load;
  assign dbg_state_o = r_state;

  sat_counter #(
    .W(STALL_CNT_W)
  ) u_stall_cnt (
    .CLK   (CLK),
    .nRST  (nRST),
    .i_inc (mem_stall_o),
    .o_cnt (stall_cnt_o)
  );

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Self-checking bench for mem_access_ctrl.
module tb_mem_access_ctrl;
  import cpu_types_pkg::*;

  logic                   CLK;
  logic                   nRST;
  logic                   ex_DRen_i;
  logic                   ex_DWen_i;
  word_t                  ex_addr_i;
  word_t                  ex_store_i;
  logic                   ex_halt_i;
  logic                   dmemREN;
  logic                   dmemWEN;
  word_t                  dmemaddr;
  word_t                  dmemstore;
  logic                   dhit;
  word_t                  dmemload;
  logic                   dcache_halt_o;
  logic                   flushed_i;
  logic                   mem_stall_o;
  logic                   wb_valid_o;
  word_t                  wb_load_o;
  logic                   halt_o;
  logic                   align_err_o;
  logic [STALL_CNT_W-1:0] stall_cnt_o;
  memstate_t              dbg_state_o;

  int tests_run;
  int tests_failed;
  logic [31:0] exp_q[$];
  logic [31:0] exp_load;
  logic [15:0] exp_cnt;

  mem_access_ctrl dut (
    .CLK           (CLK),
    .nRST          (nRST),
    .ex_DRen_i     (ex_DRen_i),
    .ex_DWen_i     (ex_DWen_i),
    .ex_addr_i     (ex_addr_i),
    .ex_store_i    (ex_store_i),
    .ex_halt_i     (ex_halt_i),
    .dmemREN       (dmemREN),
    .dmemWEN       (dmemWEN),
    .dmemaddr      (dmemaddr),
    .dmemstore     (dmemstore),
    .dhit          (dhit),
    .dmemload      (dmemload),
    .dcache_halt_o (dcache_halt_o),
    .flushed_i     (flushed_i),
    .mem_stall_o   (mem_stall_o),
    .wb_valid_o    (wb_valid_o),
    .wb_load_o     (wb_load_o),
    .halt_o        (halt_o),
    .align_err_o   (align_err_o),
    .stall_cnt_o   (stall_cnt_o),
    .dbg_state_o   (dbg_state_o)
  );

  // Clock and watchdog.
  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  initial begin
    #1500000;
    $display("FAIL watchdog: time limit reached, required finish before it");
    $fatal(1);
  end

  // Start a cycle: just after the rising edge, where inputs are driven.
  task automatic next_cycle();
    @(posedge CLK);
    #1;
  endtask

  task automatic clear_inputs();
    ex_DRen_i  = 1'b0;
    ex_DWen_i  = 1'b0;
    ex_addr_i  = '0;
    ex_store_i = '0;
    ex_halt_i  = 1'b0;
    dhit       = 1'b0;
    dmemload   = '0;
    flushed_i  = 1'b0;
  endtask

  task automatic do_reset();
    next_cycle();
    clear_inputs();
    nRST = 1'b0;
    next_cycle();
    next_cycle();
    nRST = 1'b1;
    exp_cnt  = '0;
    exp_load = '0;
  endtask

  task automatic test_reset();
    next_cycle();
    clear_inputs();
    nRST = 1'b0;
    #2;
    tests_run++;
    if ({dmemREN, dmemWEN, dcache_halt_o, mem_stall_o, wb_valid_o, halt_o, align_err_o} !== 7'b0) begin
      tests_failed++;
      $display("FAIL reset_flags: got %b, required 0000000",
               {dmemREN, dmemWEN, dcache_halt_o, mem_stall_o, wb_valid_o, halt_o, align_err_o});
    end
    tests_run++;
    if ({dmemaddr, dmemstore, wb_load_o} !== 96'h0) begin
      tests_failed++;
      $display("FAIL reset_words: addr %h store %h load %h, required all 0", dmemaddr, dmemstore, wb_load_o);
    end
    tests_run++;
    if (stall_cnt_o !== 16'h0 || dbg_state_o !== IDLE) begin
      tests_failed++;
      $display("FAIL reset_cnt_state: cnt %h state %0d, required 0 / IDLE", stall_cnt_o, dbg_state_o);
    end
    next_cycle();
    nRST = 1'b1;
    exp_cnt  = '0;
    exp_load = '0;
  endtask

  // Aligned load, dhit in the first ACCESS cycle.
  task automatic test_load();
    logic [31:0] e;
    next_cycle();
    ex_DRen_i = 1'b1;
    ex_addr_i = 32'h0000_0040;
    exp_load  = 32'hDEAD_BEEF;
    exp_q.push_back(exp_load);
    @(negedge CLK);
    tests_run++;
    if (mem_stall_o !== 1'b1 || dmemREN !== 1'b0) begin
      tests_failed++;
      $display("FAIL load_c0: stall %b ren %b, required 1 / 0", mem_stall_o, dmemREN);
    end
    exp_cnt++;
    next_cycle();
    ex_DRen_i = 1'b0;
    ex_addr_i = '0;
    dhit      = 1'b1;
    dmemload  = 32'hDEAD_BEEF;
    @(negedge CLK);
    tests_run++;
    if (dmemREN !== 1'b1 || dmemWEN !== 1'b0 || dmemaddr !== 32'h40 || mem_stall_o !== 1'b1) begin
      tests_failed++;
      $display("FAIL load_c1: ren %b wen %b addr %h stall %b, required 1 0 00000040 1",
               dmemREN, dmemWEN, dmemaddr, mem_stall_o);
    end
    exp_cnt++;
    next_cycle();
    dhit     = 1'b0;
    dmemload = '0;
    @(negedge CLK);
    tests_run++;
    if (wb_valid_o !== 1'b1 || mem_stall_o !== 1'b0 || dmemREN !== 1'b0) begin
      tests_failed++;
      $display("FAIL load_c2: valid %b stall %b ren %b, required 1 0 0", wb_valid_o, mem_stall_o, dmemREN);
    end
    if (wb_valid_o === 1'b1) begin
      tests_run++;
      if (exp_q.size() == 0) begin
        tests_failed++;
        $display("FAIL load_sb: wb_valid_o with no expected entry");
      end else begin
        e = exp_q.pop_front();
        if (wb_load_o !== e) begin
          tests_failed++;
          $display("FAIL load_data: got %h, required %h", wb_load_o, e);
        end
      end
    end
    tests_run++;
    if (stall_cnt_o !== exp_cnt) begin
      tests_failed++;
      $display("FAIL load_cnt: got %0d, required %0d", stall_cnt_o, exp_cnt);
    end
    next_cycle();
    @(negedge CLK);
    tests_run++;
    if (wb_valid_o !== 1'b0 || dbg_state_o !== IDLE || wb_load_o !== exp_load) begin
      tests_failed++;
      $display("FAIL load_c3: valid %b state %0d load %h, required 0 IDLE %h",
               wb_valid_o, dbg_state_o, wb_load_o, exp_load);
    end
  endtask

  // Store (both enables set: write wins), dhit after 5 ACCESS cycles.
  task automatic test_store_delay();
    logic [31:0] e;
    logic [15:0] cnt_start;
    cnt_start = exp_cnt;
    next_cycle();
    ex_DRen_i  = 1'b1;
    ex_DWen_i  = 1'b1;
    ex_addr_i  = 32'h0000_0080;
    ex_store_i = 32'h1234_5678;
    exp_q.push_back(exp_load);
    @(negedge CLK);
    exp_cnt++;
    for (int i = 1; i <= 5; i++) begin
      next_cycle();
      ex_DWen_i  = 1'($urandom_range(0, 1));
      ex_addr_i  = $urandom;
      ex_store_i = $urandom;
      dhit       = (i == 5);
      dmemload   = $urandom;
      @(negedge CLK);
      tests_run++;
      if (dmemWEN !== 1'b1 || dmemREN !== 1'b0 || dmemaddr !== 32'h80 ||
          dmemstore !== 32'h1234_5678 || mem_stall_o !== 1'b1) begin
        tests_failed++;
        $display("FAIL store_access%0d: wen %b ren %b addr %h data %h stall %b, required 1 0 00000080 12345678 1",
                 i, dmemWEN, dmemREN, dmemaddr, dmemstore, mem_stall_o);
      end
      exp_cnt++;
    end
    next_cycle();
    clear_inputs();
    @(negedge CLK);
    tests_run++;
    if (wb_valid_o !== 1'b1 || dmemWEN !== 1'b0) begin
      tests_failed++;
      $display("FAIL store_done: valid %b wen %b, required 1 0", wb_valid_o, dmemWEN);
    end
    if (wb_valid_o === 1'b1) begin
      tests_run++;
      if (exp_q.size() == 0) begin
        tests_failed++;
        $display("FAIL store_sb: wb_valid_o with no expected entry");
      end else begin
        e = exp_q.pop_front();
        if (wb_load_o !== e) begin
          tests_failed++;
          $display("FAIL store_load_kept: got %h, required %h", wb_load_o, e);
        end
      end
    end
    tests_run++;
    if (stall_cnt_o - cnt_start !== 16'd6 || stall_cnt_o !== exp_cnt) begin
      tests_failed++;
      $display("FAIL store_cnt: got %0d, required %0d", stall_cnt_o, exp_cnt);
    end
  endtask

  // Misaligned load: error pulse, no request, no stall.
  task automatic test_misaligned();
    next_cycle();
    ex_DRen_i = 1'b1;
    ex_addr_i = 32'h0000_0042;
    @(negedge CLK);
    tests_run++;
    if (align_err_o !== 1'b1 || mem_stall_o !== 1'b0 || dmemREN !== 1'b0) begin
      tests_failed++;
      $display("FAIL misalign_c0: err %b stall %b ren %b, required 1 0 0", align_err_o, mem_stall_o, dmemREN);
    end
    for (int i = 1; i <= 2; i++) begin
      next_cycle();
      clear_inputs();
      @(negedge CLK);
      tests_run++;
      if (align_err_o !== 1'b0 || dmemREN !== 1'b0 || dbg_state_o !== IDLE || stall_cnt_o !== exp_cnt) begin
        tests_failed++;
        $display("FAIL misalign_c%0d: err %b ren %b state %0d cnt %0d, required 0 0 IDLE %0d",
                 i, align_err_o, dmemREN, dbg_state_o, stall_cnt_o, exp_cnt);
      end
    end
  endtask

  // Halt: flush for 3 cycles, flushed_i in the third, then HALTED held.
  task automatic test_halt();
    next_cycle();
    ex_halt_i = 1'b1;
    flushed_i = 1'b1;
    @(negedge CLK);
    tests_run++;
    if (dcache_halt_o !== 1'b0 || mem_stall_o !== 1'b0 || halt_o !== 1'b0) begin
      tests_failed++;
      $display("FAIL halt_c0: dhalt %b stall %b halt %b, required 0 0 0", dcache_halt_o, mem_stall_o, halt_o);
    end
    for (int i = 1; i <= 3; i++) begin
      next_cycle();
      flushed_i = (i == 3);
      dhit      = 1'b1;
      @(negedge CLK);
      tests_run++;
      if (dcache_halt_o !== 1'b1 || halt_o !== 1'b0 || mem_stall_o !== 1'b1 || dbg_state_o !== FLUSH) begin
        tests_failed++;
        $display("FAIL halt_flush%0d: dhalt %b halt %b stall %b state %0d, required 1 0 1 FLUSH",
                 i, dcache_halt_o, halt_o, mem_stall_o, dbg_state_o);
      end
      exp_cnt++;
    end
    for (int i = 4; i <= 6; i++) begin
      next_cycle();
      clear_inputs();
      @(negedge CLK);
      tests_run++;
      if (halt_o !== 1'b1 || dcache_halt_o !== 1'b1 || mem_stall_o !== 1'b1 || stall_cnt_o !== exp_cnt) begin
        tests_failed++;
        $display("FAIL halt_held%0d: halt %b dhalt %b stall %b cnt %0d, required 1 1 1 %0d",
                 i, halt_o, dcache_halt_o, mem_stall_o, stall_cnt_o, exp_cnt);
      end
      exp_cnt++;
    end
  endtask

  // Reset asserted in the middle of an ACCESS cycle.
  task automatic test_reset_mid_access();
    do_reset();
    next_cycle();
    ex_DRen_i = 1'b1;
    ex_addr_i = 32'h0000_0100;
    next_cycle();
    clear_inputs();
    @(negedge CLK);
    tests_run++;
    if (dmemREN !== 1'b1 || dmemaddr !== 32'h100) begin
      tests_failed++;
      $display("FAIL rst_mid_pre: ren %b addr %h, required 1 00000100", dmemREN, dmemaddr);
    end
    #1;
    nRST = 1'b0;
    #1;
    tests_run++;
    if (dmemREN !== 1'b0 || dmemaddr !== 32'h0 || mem_stall_o !== 1'b0 || wb_valid_o !== 1'b0 ||
        dbg_state_o !== IDLE || stall_cnt_o !== 16'h0 || wb_load_o !== 32'h0) begin
      tests_failed++;
      $display("FAIL rst_mid_async: ren %b addr %h stall %b valid %b state %0d cnt %0d load %h, required all 0 / IDLE",
               dmemREN, dmemaddr, mem_stall_o, wb_valid_o, dbg_state_o, stall_cnt_o, wb_load_o);
    end
    next_cycle();
    nRST = 1'b1;
    exp_cnt  = '0;
    exp_load = '0;
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      tests_run++;
      if (wb_valid_o !== 1'b0 || dbg_state_o !== IDLE || dmemREN !== 1'b0) begin
        tests_failed++;
        $display("FAIL rst_mid_after%0d: valid %b state %0d ren %b, required 0 IDLE 0",
                 i, wb_valid_o, dbg_state_o, dmemREN);
      end
      next_cycle();
    end
  endtask

  // Long HALTED stall drives the counter into saturation.
  task automatic test_saturate();
    do_reset();
    next_cycle();
    ex_halt_i = 1'b1;
    flushed_i = 1'b1;
    @(negedge CLK);
    for (int c = 1; c < 65545; c++) begin
      next_cycle();
      ex_halt_i = 1'b0;
      if (c == 2) flushed_i = 1'b0;
      @(negedge CLK);
      if (c == 2) begin
        tests_run++;
        if (halt_o !== 1'b1) begin
          tests_failed++;
          $display("FAIL sat_halted: halt %b, required 1", halt_o);
        end
      end
      if (exp_cnt >= 16'hFFFD) begin
        tests_run++;
        if (stall_cnt_o !== exp_cnt) begin
          tests_failed++;
          $display("FAIL sat_cnt c%0d: got %h, required %h", c, stall_cnt_o, exp_cnt);
        end
      end
      if (exp_cnt != 16'hFFFF) exp_cnt++;
    end
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    nRST         = 1'b0;
    clear_inputs();
    test_reset();
    test_load();
    test_store_delay();
    test_misaligned();
    test_halt();
    test_reset_mid_access();
    test_saturate();
    tests_run++;
    if (exp_q.size() != 0) begin
      tests_failed++;
      $display("FAIL scoreboard_drain: %0d entries left, required 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/mem_access_ctrl.md
MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

Interface
REQ-001 SHALL have port CLK, in, 1, rising-edge clock.
REQ-002 SHALL have port nRST, in, 1, reset, asynchronous, active-low.
REQ-003 SHALL have ports ex_DRen_i and ex_DWen_i, in, 1 each, load/store request from the EX/MEM latch outputs.
REQ-004 SHALL have ports ex_addr_i and ex_store_i, in, 32 each, ALU address and store data from the EX/MEM latch.
REQ-005 SHALL have port ex_halt_i, in, 1, halt flag from the EX/MEM latch.
REQ-006 SHALL have ports dmemREN and dmemWEN, out, 1 each, read/write request to the dcache.
REQ-007 SHALL have ports dmemaddr and dmemstore, out, 32 each, request address and store data.
REQ-008 SHALL have ports dhit, in, 1, and dmemload, in, 32, for dcache completion and load data.
REQ-009 SHALL have ports dcache_halt_o, out, 1, flush request, and flushed_i, in, 1, flush done.
REQ-010 SHALL have ports mem_stall_o, out, 1, hold upstream latches, and wb_valid_o, out, 1, access-complete pulse.
REQ-011 SHALL have ports wb_load_o, out, 32, captured load word, and halt_o, out, 1, CPU halted.
REQ-012 SHALL have ports align_err_o, out, 1, misaligned pulse, and stall_cnt_o, out, 16, stall-cycle count.

Function
REQ-013 SHALL implement FSM states IDLE, ACCESS, DONE, FLUSH, HALTED.
REQ-014 SHALL define a request in IDLE as (ex_DRen_i|ex_DWen_i) with ex_addr_i[1:0]==0.
REQ-015 SHALL, in IDLE with a request, latch type/addr/data and go to ACCESS next cycle; ex_DWen_i wins when both enables are set.
REQ-016 SHALL, in IDLE with misaligned enables, pulse align_err_o for 1 cycle, issue no request, stay IDLE.
REQ-017 SHALL drive dmemREN/dmemWEN/dmemaddr/dmemstore only from latched registers, and only in ACCESS; all are 0 elsewhere.
REQ-018 SHALL stay in ACCESS until dhit=1; on dhit go to DONE and, for reads, capture dmemload into wb_load_o.
REQ-019 SHALL hold wb_load_o until the next read completion; writes SHALL NOT modify it.
REQ-020 SHALL assert wb_valid_o for exactly the one DONE cycle; DONE SHALL always return to IDLE.
REQ-021 SHALL assert mem_stall_o in IDLE-with-request, ACCESS, FLUSH and HALTED; 0 in DONE and in IDLE without request.
REQ-022 SHALL give a minimum latency of request-seen cycle 0, ACCESS cycle 1, DONE cycle 2, when dhit occurs in cycle 1.
REQ-023 SHALL, in IDLE with ex_halt_i=1 and no request, go to FLUSH; a pending request SHALL be served first.
REQ-024 SHALL drive dcache_halt_o=1 in FLUSH; flushed_i=1 SHALL move to HALTED.
REQ-025 SHALL keep HALTED, with halt_o=1 and dcache_halt_o=1, until reset.
REQ-026 SHALL increment stall_cnt_o each cycle mem_stall_o=1, saturating at 16'hFFFF without wrap.
REQ-027 SHALL ignore dhit outside ACCESS and flushed_i outside FLUSH.

Reset
REQ-028 SHALL, on nRST low, asynchronously set the state to IDLE and clear every output, wb_load_o, latched registers and stall_cnt_o to 0.
REQ-029 SHALL, on reset during ACCESS or FLUSH, drop requests immediately and issue no wb_valid_o pulse.

Structure
REQ-030 SHALL place word_t and the FSM state enum memstate_t in cpu_types_pkg.
REQ-031 SHALL take the 16-bit counter width as a package constant.
REQ-032 SHALL implement the saturating counter as the sub-module sat_counter; everything else is a single module.

Verification
REQ-033 SHALL cover: load at 0x0000_0040 with dhit in the first ACCESS cycle, dmemload=0xDEADBEEF -> stall cycles 0-1, wb_valid_o cycle 2, wb_load_o=0xDEADBEEF.
REQ-034 SHALL cover: store of 0x1234_5678 to 0x80 with dhit delayed 5 cycles -> dmemWEN held 5 cycles, addr/data stable, wb_load_o unchanged, stall_cnt_o=6.
REQ-035 SHALL cover: ex_DRen_i=1, addr 0x42 -> align_err_o 1-cycle pulse, dmemREN never set, no stall.
REQ-036 SHALL cover: ex_halt_i=1, flushed_i after 3 cycles -> dcache_halt_o set from cycle 1, halt_o=1 from cycle 4, held.
REQ-037 SHALL cover: nRST pulsed mid-ACCESS -> dmemREN low asynchronously, state IDLE, all outputs 0, no wb_valid_o.
REQ-038 SHALL cover: stall_cnt_o preloaded near 0xFFFF by forced long stalls -> stays 0xFFFF, no wrap.
